// File: rtl/pal_serial.sv
// rtl/pal_serial.sv - parallel-to-serial converter with 2-entry input FIFO
//
// Purpose: accepts WIDTH-bit words through a valid/ready handshake into a
// 2-entry FIFO and shifts them out MSB first, one bit per clock.
// Optional feature macro: PAL_SERIAL_GAP_EN inserts one idle cycle (en=0)
// after every word so a downstream deserializer can sample its output.
//
// Ports:
//   clk        - rising-edge clock
//   reset      - synchronous, active-high reset
//   din        - parallel word to serialize
//   din_valid  - din holds a word to be accepted
//   din_ready  - a word can be accepted this cycle (FIFO not full)
//   out        - serial data bit, MSB first
//   en         - out is valid this cycle (downstream shift enable)
//   word_done  - one-cycle pulse while the last bit of a word is on out
//   busy       - FSM not idle or FIFO non-empty
module pal_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             out,
  output logic             en,
  output logic             word_done,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PAL_SERIAL_GAP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2} state_t;
`else
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] fifo_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q, count_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             out_q, en_q, wd_q, busy_q, ready_q;
  logic             push, pop, fifo_ne;
  logic [WIDTH-1:0] head;

  assign din_ready = ready_q;
  assign out       = out_q;
  assign en        = en_q;
  assign word_done = wd_q;
  assign busy      = busy_q;

  always_comb begin
    push    = din_valid && ready_q;
    pop     = 1'b0;
    fifo_ne = (count_q != 2'd0);
    head    = fifo_q[rd_ptr_q];
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (fifo_ne) begin
          pop     = 1'b1;
          shreg_d = head;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == LAST) begin
          shreg_d = '0;
          cnt_d   = '0;
`ifdef PAL_SERIAL_GAP_EN
          state_d = GAP;
`else
          // Reload at the same edge so en stays high across words.
          if (fifo_ne) begin
            pop     = 1'b1;
            shreg_d = head;
            state_d = SHIFT;
          end else begin
            state_d = IDLE;
          end
`endif
        end else begin
          shreg_d = shreg_q << 1;
          cnt_d   = cnt_q + CW'(1);
        end
      end
`ifdef PAL_SERIAL_GAP_EN
      GAP: begin
        if (fifo_ne) begin
          pop     = 1'b1;
          shreg_d = head;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the
  // word held in shreg during the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      shreg_q  <= '0;
      cnt_q    <= '0;
      out_q    <= 1'b0;
      en_q     <= 1'b0;
      wd_q     <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= din;
      end
      wr_ptr_q <= wr_ptr_q ^ push;
      rd_ptr_q <= rd_ptr_q ^ pop;
      count_q  <= count_d;
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      en_q     <= (state_d == SHIFT);
      out_q    <= (state_d == SHIFT) && shreg_d[WIDTH-1];
      wd_q     <= (state_d == SHIFT) && (cnt_d == LAST);
      busy_q   <= (state_d != IDLE) || (count_d != 2'd0);
      ready_q  <= (count_d != 2'd2);
    end
  end

endmodule
